audio_cfg_seq: RTL

AUDIO_CFG_SEQ -- requirements
Module: audio_cfg_seq

---
 rtl/audio_cfg_seq.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_cfg_seq.sv
// audio_cfg_seq: writes a fixed 11-entry WM8731 register table over an
// open-drain I2C bus, one START..STOP transaction per entry.
// Optional build macro AUDIO_CFG_RETRY_EN: a NACKed entry is retried after
// the inter-transaction gap, up to 3 retries, before error is raised.
// Without it the first NACK ends the sequence in the error state.
module audio_cfg_seq #(
  parameter int         CLK_HZ   = 50000000,
  parameter int         I2C_HZ   = 100000,
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk_clk,
  input  logic       reset_n_reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] entry_idx,
  output logic       i2c_sclk,
  output logic       i2c_sdat_oe,
  input  logic       i2c_sdat_in
);

  // Quarter-bit period in system clocks; clamp so tiny ratios still tick.
  localparam int Q_RAW = CLK_HZ / (4 * I2C_HZ);
  localparam int Q     = (Q_RAW < 1) ? 1 : Q_RAW;
  localparam int QW    = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);

  localparam logic [3:0] LAST_ENTRY = 4'd10;
  localparam logic [2:0] GAP_LAST   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      state;
  logic [1:0]  ph;        // quarter within the current bit / condition
  logic [2:0]  bitn;      // bits remaining in current byte minus one
  logic [1:0]  byte_sel;  // 0 = address, 1 = {reg,data[8]}, 2 = data[7:0]
  logic [7:0]  shreg;
  logic [2:0]  gcnt;
  logic        nack_f;
  logic [QW-1:0] qcnt;
  logic        tick;
  logic        start_ok;
  logic        sdat_p0;
  logic        sdat_p1;
`ifdef AUDIO_CFG_RETRY_EN
  logic [1:0]  retry_cnt;
`endif

  // Register table: {reg[6:0], data[8:0]} in write order.
  function automatic logic [15:0] cfg_word(input logic [3:0] idx);
    case (idx)
      4'd0:    cfg_word = {7'd15, 9'h000};
      4'd1:    cfg_word = {7'd0,  9'h017};
      4'd2:    cfg_word = {7'd1,  9'h017};
      4'd3:    cfg_word = {7'd2,  9'h079};
      4'd4:    cfg_word = {7'd3,  9'h079};
      4'd5:    cfg_word = {7'd4,  9'h012};
      4'd6:    cfg_word = {7'd5,  9'h000};
      4'd7:    cfg_word = {7'd6,  9'h000};
      4'd8:    cfg_word = {7'd7,  9'h042};
      4'd9:    cfg_word = {7'd8,  9'h000};
      default: cfg_word = {7'd9,  9'h001};
    endcase
  endfunction

  // Byte sel of the transaction for table entry idx.
  function automatic logic [7:0] byte_of(input logic [3:0] idx, input logic [1:0] sel);
    logic [15:0] w;
    w = cfg_word(idx);
    case (sel)
      2'd0:    byte_of = {DEV_ADDR, 1'b0};
      2'd1:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign tick     = busy && (qcnt == Q_LAST);

  // Two-flop synchroniser for the asynchronous SDAT pad input.
  always_ff @(posedge clk_clk) begin
    sdat_p0 <= i2c_sdat_in;
    sdat_p1 <= sdat_p0;
  end

  // Quarter-bit tick counter; held at zero whenever no sequence is running.
  always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      qcnt <= '0;
    end else if (!busy || tick) begin
      qcnt <= '0;
    end else begin
      qcnt <= qcnt + 1'b1;
    end
  end

  // Sequencer FSM: all bus lines and status flags are registered here.
  always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      state       <= ST_IDLE;
      ph          <= 2'd0;
      bitn        <= 3'd0;
      byte_sel    <= 2'd0;
      shreg       <= 8'd0;
      gcnt        <= 3'd0;
      nack_f      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      entry_idx   <= 4'd0;
      i2c_sclk    <= 1'b1;
      i2c_sdat_oe <= 1'b0;
`ifdef AUDIO_CFG_RETRY_EN
      retry_cnt   <= 2'd0;
`endif
    end else if (start_ok) begin
      state       <= ST_START;
      ph          <= 2'd0;
      nack_f      <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      entry_idx   <= 4'd0;
      i2c_sclk    <= 1'b1;
      i2c_sdat_oe <= 1'b0;
`ifdef AUDIO_CFG_RETRY_EN
      retry_cnt   <= 2'd0;
`endif
    end else if (tick) begin
      case (state)
        // START: SDAT falls with SCLK high, SCLK falls one tick later.
        ST_START: begin
          if (ph == 2'd0) begin
            i2c_sdat_oe <= 1'b1;
            ph          <= 2'd1;
          end else begin
            i2c_sclk <= 1'b0;
            ph       <= 2'd0;
            bitn     <= 3'd7;
            byte_sel <= 2'd0;
            shreg    <= byte_of(entry_idx, 2'd0);
            state    <= ST_BIT;
          end
        end
        // Data bit: set SDAT in quarter 0 (SCLK low), SCLK high in 1-2.
        ST_BIT: begin
          case (ph)
            2'd0: begin
              i2c_sdat_oe <= ~shreg[7];
              ph          <= 2'd1;
            end
            2'd1: begin
              i2c_sclk <= 1'b1;
              ph       <= 2'd2;
            end
            2'd2: ph <= 2'd3;
            2'd3: begin
              i2c_sclk <= 1'b0;
              ph       <= 2'd0;
              shreg    <= {shreg[6:0], 1'b0};
              if (bitn == 3'd0) begin
                state <= ST_ACK;
              end else begin
                bitn <= bitn - 3'd1;
              end
            end
          endcase
        end
        // ACK slot: release SDAT, sample at the SCLK-high midpoint.
        ST_ACK: begin
          case (ph)
            2'd0: begin
              i2c_sdat_oe <= 1'b0;
              ph          <= 2'd1;
            end
            2'd1: begin
              i2c_sclk <= 1'b1;
              ph       <= 2'd2;
            end
            2'd2: begin
              nack_f <= sdat_p1;
              ph     <= 2'd3;
            end
            2'd3: begin
              i2c_sclk <= 1'b0;
              ph       <= 2'd0;
              if (nack_f || (byte_sel == 2'd2)) begin
                state <= ST_STOP;
              end else begin
                byte_sel <= byte_sel + 2'd1;
                shreg    <= byte_of(entry_idx, byte_sel + 2'd1);
                bitn     <= 3'd7;
                state    <= ST_BIT;
              end
            end
          endcase
        end
        // STOP: pull SDAT low with SCLK low, raise SCLK, then release SDAT.
        ST_STOP: begin
          case (ph)
            2'd0: begin
              i2c_sdat_oe <= 1'b1;
              ph          <= 2'd1;
            end
            2'd1: begin
              i2c_sclk <= 1'b1;
              ph       <= 2'd2;
            end
            2'd2: begin
              i2c_sdat_oe <= 1'b0;
              ph          <= 2'd3;
            end
            2'd3: begin
              ph <= 2'd0;
              if (nack_f) begin
`ifdef AUDIO_CFG_RETRY_EN
                if (retry_cnt == 2'd3) begin
                  state <= ST_ERR;
                  busy  <= 1'b0;
                  error <= 1'b1;
                end else begin
                  retry_cnt <= retry_cnt + 2'd1;
                  gcnt      <= 3'd0;
                  state     <= ST_GAP;
                end
`else
                state <= ST_ERR;
                busy  <= 1'b0;
                error <= 1'b1;
`endif
              end else if (entry_idx == LAST_ENTRY) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                gcnt  <= 3'd0;
                state <= ST_GAP;
              end
            end
          endcase
        end
        // Bus idle for 8 ticks; advance the entry unless retrying it.
        ST_GAP: begin
          if (gcnt == GAP_LAST) begin
            state  <= ST_START;
            ph     <= 2'd0;
            nack_f <= 1'b0;
            if (!nack_f) begin
              entry_idx <= entry_idx + 4'd1;
`ifdef AUDIO_CFG_RETRY_EN
              retry_cnt <= 2'd0;
`endif
            end
          end else begin
            gcnt <= gcnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
